// File: rtl/xor_parity_acc_if.sv
// Word-source handshake and parity-result bundle for xor_parity_acc.
// When XOR_CHECK_EN is defined the bundle also carries chk_bit and par_err.
`timescale 1ns/1ps

interface xor_parity_acc_if #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             par_out;
    logic             par_valid;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;
`ifdef XOR_CHECK_EN
    logic             chk_bit;
    logic             par_err;
`endif

    // Word source / frame checker side
    modport master (
        output start, din, din_valid,
`ifdef XOR_CHECK_EN
        output chk_bit,
        input  par_err,
`endif
        input  din_ready, par_out, par_valid, busy, word_cnt
    );

    // Parity accumulator side
    modport slave (
        input  start, din, din_valid,
`ifdef XOR_CHECK_EN
        input  chk_bit,
        output par_err,
`endif
        output din_ready, par_out, par_valid, busy, word_cnt
    );
endinterface

// File: rtl/xor_parity_acc.sv
// Clocked parity accumulator: reduces each WIDTH-bit word to a parity bit and
// XOR-accumulates FRAME_LEN of them into one registered frame parity result.
// Optional feature macro: XOR_CHECK_EN (adds chk_bit input / par_err output).
`timescale 1ns/1ps

module xor_parity_acc #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic               clk,
    input  logic               rst,
    xor_parity_acc_if.slave    pif
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic             acc_reg;
    logic [CNT_W-1:0] word_cnt_reg;
    logic             din_ready_reg;
    logic             busy_reg;
    logic             par_out_reg;
    logic             par_valid_reg;
`ifdef XOR_CHECK_EN
    logic             par_err_reg;
`endif

    // Bitwise parity of the incoming word as an XOR chain
    logic [WIDTH:0] par_chain;
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ pif.din[gi];
        end
    endgenerate

    logic word_par;
    logic accept;
    logic acc_next;
    logic last_word;

    assign word_par  = par_chain[WIDTH];
    assign accept    = (state_reg == ST_ACC) && pif.din_valid;
    assign acc_next  = acc_reg ^ word_par;
    assign last_word = (word_cnt_reg == LAST_CNT);

    // Frame FSM; every output is a register so din_ready/busy/par_* follow the state exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= 1'b0;
            word_cnt_reg  <= '0;
            din_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            par_out_reg   <= 1'b0;
            par_valid_reg <= 1'b0;
`ifdef XOR_CHECK_EN
            par_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pif.start) begin
                        state_reg     <= ST_ACC;
                        acc_reg       <= ODD_BIT;
                        word_cnt_reg  <= '0;
                        din_ready_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        acc_reg      <= acc_next;
                        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                        if (last_word) begin
                            // Result is published during DONE, together with its valid pulse
                            state_reg     <= ST_DONE;
                            din_ready_reg <= 1'b0;
                            par_out_reg   <= acc_next;
                            par_valid_reg <= 1'b1;
`ifdef XOR_CHECK_EN
                            par_err_reg   <= (acc_next != pif.chk_bit);
`endif
                        end
                    end
                end
                ST_DONE: begin
                    // start seen here is deliberately dropped; it must be re-asserted in IDLE
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    par_valid_reg <= 1'b0;
`ifdef XOR_CHECK_EN
                    par_err_reg   <= 1'b0;
`endif
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    din_ready_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    par_valid_reg <= 1'b0;
`ifdef XOR_CHECK_EN
                    par_err_reg   <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign pif.din_ready = din_ready_reg;
    assign pif.busy      = busy_reg;
    assign pif.par_out   = par_out_reg;
    assign pif.par_valid = par_valid_reg;
    assign pif.word_cnt  = word_cnt_reg;
`ifdef XOR_CHECK_EN
    assign pif.par_err   = par_err_reg;
`endif

endmodule

// File: tb/tb_xor_parity_acc.sv
// Directed bench for xor_parity_acc: an even-parity and an odd-parity instance
// receive identical stimulus; expected values are hand-computed per frame.
`timescale 1ns/1ps

module tb_xor_parity_acc;
    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
`ifdef XOR_CHECK_EN
    logic       chk_bit = 1'b0;
`endif

    int num_checks = 0;
    int num_errors = 0;

    always #41.665 clk = ~clk;

    xor_parity_acc_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) if_even ();
    xor_parity_acc_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) if_odd ();

    assign if_even.start     = start;
    assign if_even.din       = din;
    assign if_even.din_valid = din_valid;
    assign if_odd.start      = start;
    assign if_odd.din        = din;
    assign if_odd.din_valid  = din_valid;
`ifdef XOR_CHECK_EN
    assign if_even.chk_bit   = chk_bit;
    assign if_odd.chk_bit    = chk_bit;
`endif

    xor_parity_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ODD(0)) dut_even (
        .clk (clk),
        .rst (rst),
        .pif (if_even)
    );

    xor_parity_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ODD(1)) dut_odd (
        .clk (clk),
        .rst (rst),
        .pif (if_odd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both instances idle with the given held word count
    task automatic check_idle(input string tag, input logic [2:0] cnt);
        check({tag, " even busy"},      32'(if_even.busy),      32'd0);
        check({tag, " even din_ready"}, 32'(if_even.din_ready), 32'd0);
        check({tag, " even par_valid"}, 32'(if_even.par_valid), 32'd0);
        check({tag, " even word_cnt"},  32'(if_even.word_cnt),  32'(cnt));
        check({tag, " odd busy"},       32'(if_odd.busy),       32'd0);
        check({tag, " odd word_cnt"},   32'(if_odd.word_cnt),   32'(cnt));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start even busy",      32'(if_even.busy),      32'd1);
        check("start even din_ready", 32'(if_even.din_ready), 32'd1);
        check("start even word_cnt",  32'(if_even.word_cnt),  32'd0);
    endtask

    // Present one word for exactly one cycle (it is accepted since din_ready is high in ACC)
    task automatic send_word(input logic [7:0] w, input logic [2:0] exp_cnt);
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check($sformatf("word 0x%02h word_cnt", w), 32'(if_even.word_cnt), 32'(exp_cnt));
    endtask

    // Checks the DONE cycle: result valid, expected parities for both instances
    task automatic check_done(input string tag, input logic exp_even, input logic exp_odd);
        check({tag, " even par_valid"}, 32'(if_even.par_valid), 32'd1);
        check({tag, " even par_out"},   32'(if_even.par_out),   32'(exp_even));
        check({tag, " odd par_valid"},  32'(if_odd.par_valid),  32'd1);
        check({tag, " odd par_out"},    32'(if_odd.par_out),    32'(exp_odd));
        check({tag, " busy in DONE"},   32'(if_even.busy),      32'd1);
        check({tag, " din_ready DONE"}, 32'(if_even.din_ready), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_idle("reset", 3'd0);
        check("reset even par_out", 32'(if_even.par_out), 32'd0);
        check("reset odd par_out",  32'(if_odd.par_out),  32'd0);
        rst = 1'b0;
        tick();
        check_idle("post-reset", 3'd0);

        // Tests 1 and 3: 0x01,0x03,0x07,0x00 back-to-back; parities 1,0,1,0
        do_start();
        send_word(8'h01, 3'd1);
        check("t1 no early par_valid", 32'(if_even.par_valid), 32'd0);
        send_word(8'h03, 3'd2);
        send_word(8'h07, 3'd3);
        send_word(8'h00, 3'd4);
        check_done("t1", 1'b0, 1'b1);
        tick();
        check_idle("t1 after", 3'd4);
        check("t1 par_out held", 32'(if_even.par_out), 32'd0);
        check("t1 odd par_out held", 32'(if_odd.par_out), 32'd1);

        // Test 2: 0x01,0x00,0x00,0x00 with 3 idle cycles between words
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_word((i == 0) ? 8'h01 : 8'h00, 3'(i + 1));
            if (i < 3) begin
                repeat (3) tick();
                check("t2 gap din_ready", 32'(if_even.din_ready), 32'd1);
                check("t2 gap word_cnt",  32'(if_even.word_cnt),  32'(i + 1));
            end
        end
        check_done("t2", 1'b1, 1'b0);
        tick();
        check_idle("t2 after", 3'd4);

        // Test 4: reset mid-frame, then a fresh 0xFF x4 frame
        do_start();
        send_word(8'h01, 3'd1);
        send_word(8'h02, 3'd2);
        rst = 1'b1;
        #5;
        check_idle("t4 async rst", 3'd0);
        check("t4 rst par_out", 32'(if_even.par_out), 32'd0);
        check("t4 rst odd par_out", 32'(if_odd.par_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t4 no par_valid", 32'(if_even.par_valid), 32'd0);
        do_start();
        for (int i = 0; i < 4; i++) send_word(8'hFF, 3'(i + 1));
        check_done("t4", 1'b0, 1'b1);
        tick();

        // Test 5: start mid-ACC ignored; start in DONE ignored; din_valid in IDLE ignored
        do_start();
        send_word(8'h07, 3'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5 restart ignored cnt", 32'(if_even.word_cnt), 32'd1);
        check("t5 restart busy",        32'(if_even.busy),     32'd1);
        send_word(8'h80, 3'd2);
        send_word(8'h0F, 3'd3);
        send_word(8'h10, 3'd4);
        check_done("t5", 1'b1, 1'b0);
        start     = 1'b1;
        din_valid = 1'b1;
        tick();
        start = 1'b0;
        check_idle("t5 start in DONE", 3'd4);
        repeat (3) tick();
        check_idle("t5 valid in IDLE", 3'd4);
        check("t5 par_out held", 32'(if_even.par_out), 32'd1);
        din_valid = 1'b0;
        tick();

`ifdef XOR_CHECK_EN
        // Test 6: chk_bit compare on the final word (even acc=0, odd acc=1)
        for (int r = 0; r < 2; r++) begin
            do_start();
            send_word(8'h01, 3'd1);
            send_word(8'h03, 3'd2);
            send_word(8'h07, 3'd3);
            chk_bit = (r == 0);
            send_word(8'h00, 3'd4);
            chk_bit = 1'b0;
            check_done("t6", 1'b0, 1'b1);
            check($sformatf("t6 r%0d even par_err", r), 32'(if_even.par_err), (r == 0) ? 32'd1 : 32'd0);
            check($sformatf("t6 r%0d odd par_err", r),  32'(if_odd.par_err),  (r == 0) ? 32'd0 : 32'd1);
            tick();
            check("t6 par_err cleared even", 32'(if_even.par_err), 32'd0);
            check("t6 par_err cleared odd",  32'(if_odd.par_err),  32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
